// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: show-ahead FIFO controller driving an external 256x16 SB_RAM40_4K.
// Define FIFO_OVERFLOW_CNT_EN to add the saturating overflow_cnt output.
module bram_fifo_ctrl #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [DEPTH_LOG2-1:0] ram_waddr,
   output logic [WIDTH-1:0]      ram_wdata,
   output logic                  ram_we,
   output logic [DEPTH_LOG2-1:0] ram_raddr,
   output logic                  ram_re,
   input  logic [WIDTH-1:0]      ram_rdata,
`ifdef FIFO_OVERFLOW_CNT_EN
   output logic [7:0]            overflow_cnt,
`endif
   output logic [DEPTH_LOG2:0]   level
);
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  pending, head_v, skid_v;
   logic [WIDTH-1:0]      head, skid;
   logic                  pop, head_free;
   logic [1:0]            occ;
   // count never exceeds 2^N, so its MSB alone flags a full RAM
   assign in_ready  = ~count[DEPTH_LOG2];
   assign ram_we    = in_valid & in_ready;
   assign ram_waddr = wptr;
   assign ram_wdata = in_data;
   assign ram_raddr = rptr;
   assign out_valid = head_v;
   assign out_data  = head;
   assign level     = count;
   assign pop       = head_v & out_ready;
   assign head_free = ~head_v | pop;
   assign occ       = {1'b0, head_v} + {1'b0, skid_v} + {1'b0, pending} - {1'b0, pop};
   assign ram_re    = (count != '0) & (occ < 2'd2);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         if (ram_we) wptr <= wptr + DEPTH_LOG2'(1);
         if (ram_re) rptr <= rptr + DEPTH_LOG2'(1);
         count   <= count + (DEPTH_LOG2+1)'(ram_we) - (DEPTH_LOG2+1)'(ram_re);
         pending <= ram_re;
      end
   end
   // returning RAM word fills head when it frees up this edge, otherwise skid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_v <= 1'b0;
         skid_v <= 1'b0;
         head   <= '0;
         skid   <= '0;
      end else if (head_free) begin
         head_v <= skid_v | pending;
         skid_v <= skid_v & pending;
         if (skid_v) head <= skid;
         else if (pending) head <= ram_rdata;
         if (skid_v & pending) skid <= ram_rdata;
      end else if (pending) begin
         skid   <= ram_rdata;
         skid_v <= 1'b1;
      end
   end
`ifdef FIFO_OVERFLOW_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow_cnt <= '0;
      else if (in_valid & ~in_ready & (overflow_cnt != 8'hFF)) overflow_cnt <= overflow_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: queue-model scoreboard plus directed checks for bram_fifo_ctrl.
module tb_bram_fifo_ctrl;
   logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [15:0] in_data = '0, out_data, ram_wdata, ram_rdata = '0;
   logic        in_ready, out_valid, ram_we, ram_re;
   logic [7:0]  ram_waddr, ram_raddr;
   logic [8:0]  level;
`ifdef FIFO_OVERFLOW_CNT_EN
   logic [7:0]  overflow_cnt;
`endif
   int total = 0, bad = 0;

   bram_fifo_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
`ifdef FIFO_OVERFLOW_CNT_EN
      .overflow_cnt(overflow_cnt),
`endif
      .level(level)
   );

   always #5 clk = ~clk;

   // SB_RAM40_4K behaviour: registered read, data valid the cycle after ram_re
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: words in RAM, one word in flight, words in the output stage
   logic [15:0] ram_q[$], out_q[$];
   logic [15:0] fly_w, last_pop;
   bit          fly;
   int          pops = 0;

   function automatic void exp_calc(output bit p, output bit r, output bit w);
      p = out_q.size() > 0 && out_ready;
      r = ram_q.size() > 0 && (out_q.size() + int'(fly) - int'(p) < 2);
      w = in_valid && ram_q.size() < 256;
   endfunction

   always @(posedge clk) begin
      bit p, r, w;
      if (reset) begin
         ram_q.delete();
         out_q.delete();
         fly = 0;
      end else begin
         exp_calc(p, r, w);
         if (p) begin
            last_pop = out_q.pop_front();
            pops++;
         end
         if (fly) out_q.push_back(fly_w);
         fly = r;
         if (r) fly_w = ram_q.pop_front();
         if (w) ram_q.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      bit p, r, w;
      if (!reset) begin
         exp_calc(p, r, w);
         chk("in_ready", in_ready, ram_q.size() != 256);
         chk("out_valid", out_valid, out_q.size() > 0);
         if (out_q.size() > 0) chk("out_data", out_data, out_q[0]);
         chk("level", level, ram_q.size());
         chk("ram_re", ram_re, r);
         chk("ram_we", ram_we, w);
         if (ram_re) chk("re_nonempty", level != 0, 1);
         if (ram_re && ram_we) chk("no_collide", ram_raddr != ram_waddr, 1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      int n = 0;
      in_valid = 1;
      in_data  = d;
      while (!in_ready && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) chk("push_timeout", in_ready, 1);
      step();
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1;
      in_valid  = 0;
      while ((level != 0 || out_valid) && n < 2000) begin
         step();
         n++;
      end
      chk("drain_done", level != 0 || out_valid, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, acc, cyc;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_re", ram_re, 0);
      chk("rst_level", level, 0);
      reset = 0;

      // three back-to-back words, consumer always ready
      out_ready = 1;
      in_valid = 1; in_data = 16'h0001; step();
      in_data = 16'h0002; step();
      in_data = 16'h0003; step();
      in_valid = 0;
      chk("t1_valid0", out_valid, 1);
      chk("t1_data0", out_data, 16'h0001);
      step();
      chk("t1_data1", out_data, 16'h0002);
      step();
      chk("t1_data2", out_data, 16'h0003);
      step();
      chk("t1_empty", out_valid, 0);
      chk("t1_level", level, 0);

      // fill to 258 words with consumer stalled
      out_ready = 0;
      p0 = pops;
      for (int i = 0; i < 258; i++) push(16'(i));
      step(); step();
      chk("t2_level", level, 256);
      chk("t2_in_ready", in_ready, 0);
      chk("t2_head", out_data, 16'h0000);
      chk("t2_valid", out_valid, 1);

      // full: pop and offered write in the same cycle
      in_valid = 1; in_data = 16'h0102; out_ready = 1;
      #1;
      chk("t3_re", ram_re, 1);
      chk("t3_we", ram_we, 0);
      step();
      out_ready = 0;
      chk("t3_in_ready", in_ready, 1);
      chk("t3_level", level, 255);
      chk("t3_head", out_data, 16'h0001);
      chk("t3_we2", ram_we, 1);
      step();
      in_valid = 0;
      drain();
      chk("t3_pops", pops - p0, 259);
      chk("t3_last", last_pop, 16'h0102);

      // random traffic, pointers wrap many times
      p0 = pops; acc = 0; cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         in_valid  = $urandom_range(0, 9) < 7;
         in_data   = 16'(acc * 7 + 3);
         out_ready = $urandom_range(0, 9) < 7;
         if (in_valid && in_ready) acc++;
         step();
         cyc++;
      end
      in_valid = 0;
      chk("t4_accepted", acc, 10000);
      drain();
      chk("t4_pops", pops - p0, 10000);
      chk("t4_last", last_pop, 16'(9999 * 7 + 3));

      // reset with a read in flight and 100 words in RAM
      out_ready = 0;
      for (int i = 0; i < 102; i++) push(16'(16'h3000 + i));
      step(); step();
      chk("t5_level_pre", level, 100);
      in_valid = 1; in_data = 16'h3066; out_ready = 1;
      step();
      in_valid = 0; out_ready = 0;
      chk("t5_level_pend", level, 100);
      reset = 1;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_level", level, 0);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_out_data", out_data, 0);
      step();
      reset = 0;
      push(16'hBEEF);
      out_ready = 1;
      for (int n = 0; n < 20 && !out_valid; n++) step();
      chk("t5_first_valid", out_valid, 1);
      chk("t5_first_data", out_data, 16'hBEEF);
      step();
      chk("t5_after", out_valid, 0);

`ifdef FIFO_OVERFLOW_CNT_EN
      out_ready = 0;
      for (int i = 0; i < 258; i++) push(16'(i));
      in_valid = 1;
      repeat (300) step();
      in_valid = 0;
      chk("ovf_cnt", overflow_cnt, 255);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
